// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding, default port count and index-width helper for rr_arbiter.
package rr_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_e;
    localparam int NUM_PORTS_DEF = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prio_arb.sv
// prio_arb: combinational fixed-priority one-hot picker, lowest index wins.
module prio_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    assign gnt_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter with grant locking.
// Define RR_ARB_TIMEOUT_EN to force re-arbitration after MAX_HOLD consecutive grant cycles.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int MAX_HOLD  = 8,
    localparam int IW = idx_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IW-1:0]        gnt_id_o,
    output logic                 gnt_valid_o
);
    state_e               state_q;
    logic [NUM_PORTS-1:0] gnt_q, cand, ge_mask, win_hi, win_all, win;
    logic [IW-1:0]        id_q, ptr_q, win_id;
    logic                 valid_q, own_req, hit, rearb;
`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt_q;
    assign hit = (state_q == GRANT) && own_req && (cnt_q == CW'(MAX_HOLD - 1));
`else
    logic [31:0] unused_max_hold;
    assign unused_max_hold = 32'(MAX_HOLD);
    assign hit = 1'b0;
`endif
    assign own_req = |(req_i & gnt_q);
    assign rearb   = (state_q == IDLE) || !own_req || hit;
    // On timeout the owner is masked so another requester can take over.
    assign cand    = req_i & ~(hit ? gnt_q : '0);
    always_comb begin
        ge_mask = '0;
        win_id  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ge_mask[i] = IW'(i) >= ptr_q;
            if (win[i]) win_id = IW'(i);
        end
    end
    prio_arb #(.N(NUM_PORTS)) u_hi (.req_i(cand & ge_mask), .gnt_o(win_hi));
    prio_arb #(.N(NUM_PORTS)) u_all (.req_i(cand), .gnt_o(win_all));
    assign win = |win_hi ? win_hi : win_all;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else if (rearb && |win) begin
            state_q <= GRANT;
            gnt_q   <= win;
            id_q    <= win_id;
            valid_q <= 1'b1;
            ptr_q   <= (win_id == IW'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else if (!own_req) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= hit ? '0 : cnt_q + 1'b1;
`endif
        end
    end
    assign gnt_o       = gnt_q;
    assign gnt_id_o    = id_q;
    assign gnt_valid_o = valid_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench; stimulus queues the expected grant, a monitor pops and compares after each edge.
module tb_rr_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    rr_arbiter #(.NUM_PORTS(4), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset), .req_i(req),
        .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_valid_o(gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] e);
        @(negedge clk);
        reset = r;
        req   = q;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e) begin
                errors++;
                $display("FAIL gnt t=%0t: got %b expected %b", $time, gnt, e);
            end
            if (gnt_id !== idx_of(e)) begin
                errors++;
                $display("FAIL gnt_id t=%0t: got %0d expected %0d", $time, gnt_id, idx_of(e));
            end
            if (gnt_valid !== (|e)) begin
                errors++;
                $display("FAIL gnt_valid t=%0t: got %b expected %b", $time, gnt_valid, |e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with all requests pending, then first grant goes to port 0
        repeat (3) step(1'b1, 4'b1111, 4'b0000);
        step(1'b0, 4'b1111, 4'b0001);
        // owner drops for one cycle on each grant: back-to-back rotation
        step(1'b0, 4'b1110, 4'b0010);
        step(1'b0, 4'b1101, 4'b0100);
        step(1'b0, 4'b1011, 4'b1000);
        step(1'b0, 4'b0111, 4'b0001);
        step(1'b0, 4'b1110, 4'b0010);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        // single requester held, then released
        repeat (20) step(1'b0, 4'b0100, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000);
        // ptr=3: wrap-around to port 0, held while requesting
        step(1'b0, 4'b0101, 4'b0001);
        step(1'b0, 4'b0101, 4'b0001);
        // owner drops, non-owner wins without a bubble; no preemption
        step(1'b0, 4'b0100, 4'b0100);
        step(1'b0, 4'b1100, 4'b0100);
        step(1'b0, 4'b1000, 4'b1000);
        // reset mid-grant on port 3
        step(1'b1, 4'b1000, 4'b0000);
        step(1'b0, 4'b1010, 4'b0010);
        // grant port 1 (ptr=2), reset must return ptr to 0
        step(1'b1, 4'b0110, 4'b0000);
        step(1'b0, 4'b0110, 4'b0010);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
`ifdef RR_ARB_TIMEOUT_EN
        for (int k = 0; k < 32; k++) step(1'b0, 4'b0011, ((k / 8) % 2 == 1) ? 4'b0010 : 4'b0001);
        repeat (20) step(1'b0, 4'b0001, 4'b0001);
`else
        repeat (20) step(1'b0, 4'b0011, 4'b0001);
`endif
        step(1'b0, 4'b0000, 4'b0000);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
